// File: rtl/xbar_cfg_sequencer_pkg.sv
// Shared definitions for the crossbar configuration sequencer and the crossbar itself.
// Holds the default crossbar geometry, the per-output select vector type and the
// sequencer FSM state encoding.
package xbar_cfg_sequencer_pkg;

    localparam int XBAR_NUM_INPUTS  = 14;
    localparam int XBAR_NUM_OUTPUTS = 16;
    localparam int XBAR_NUM_CTX     = 8;
    localparam int XBAR_SEL_W       = $clog2(XBAR_NUM_INPUTS);

    // One select field per crossbar output; field k drives output k.
    typedef logic [XBAR_NUM_OUTPUTS-1:0][XBAR_SEL_W-1:0] sel_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/xbar_cfg_sequencer_ctx.sv
// Context table: NUM_CTX select vectors in flops, one synchronous write port and
// one combinational read port. Reset loads every entry with the identity mapping.
// Ports: i_we/i_waddr/i_wdata write at the rising edge; i_raddr -> o_rdata same cycle.
module xbar_ctx_table
    import xbar_cfg_sequencer_pkg::*;
#(
    parameter  int NUM_INPUTS  = XBAR_NUM_INPUTS,
    parameter  int NUM_OUTPUTS = XBAR_NUM_OUTPUTS,
    parameter  int NUM_CTX     = XBAR_NUM_CTX,
    localparam int SEL_W       = $clog2(NUM_INPUTS),
    localparam int CTX_W       = $clog2(NUM_CTX)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_we,
    input  logic [CTX_W-1:0]                  i_waddr,
    input  logic [NUM_OUTPUTS-1:0][SEL_W-1:0] i_wdata,
    input  logic [CTX_W-1:0]                  i_raddr,
    output logic [NUM_OUTPUTS-1:0][SEL_W-1:0] o_rdata
);

    logic [NUM_OUTPUTS-1:0][SEL_W-1:0] r_tbl [NUM_CTX];
    logic [NUM_OUTPUTS-1:0][SEL_W-1:0] w_ident;

    // Identity: output k selects input k mod NUM_INPUTS.
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_ident
        assign w_ident[k] = SEL_W'(k % NUM_INPUTS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_CTX; e++) begin
                r_tbl[e] <= w_ident;
            end
        end else if (i_we) begin
            r_tbl[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_tbl[i_raddr];

endmodule

// File: rtl/xbar_cfg_sequencer.sv
// Crossbar configuration sequencer: replays num_ctx stored contexts onto the crossbar
// select lines, repeat_cnt+1 passes, one context per cycle, then pulses done_o.
// Ports: cfg_* write the context table; start/num_ctx/repeat_cnt/stop control the run;
// select_o/cb_en_o/ctx_idx_o drive the crossbar; busy_o/done_o/err_o report status.
module xbar_cfg_sequencer
    import xbar_cfg_sequencer_pkg::*;
#(
    parameter  int NUM_INPUTS  = XBAR_NUM_INPUTS,
    parameter  int NUM_OUTPUTS = XBAR_NUM_OUTPUTS,
    parameter  int NUM_CTX     = XBAR_NUM_CTX,
    localparam int SEL_W       = $clog2(NUM_INPUTS),
    localparam int CTX_W       = $clog2(NUM_CTX),
    localparam int NUMC_W      = CTX_W + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_we,
    input  logic [CTX_W-1:0]                  cfg_addr,
    input  logic [NUM_OUTPUTS-1:0][SEL_W-1:0] cfg_data,
    input  logic                              start,
    input  logic [NUMC_W-1:0]                 num_ctx,
    input  logic [7:0]                        repeat_cnt,
    input  logic                              stop,
    output logic [NUM_OUTPUTS-1:0][SEL_W-1:0] select_o,
    output logic                              cb_en_o,
    output logic [CTX_W-1:0]                  ctx_idx_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]                        r_state;
    logic [NUMC_W-1:0]                 r_num;
    logic [7:0]                        r_rep;
    logic [7:0]                        r_pass;
    logic [CTX_W-1:0]                  r_ctx;

    logic                              w_num_ok;
    logic                              w_addr_ok;
    logic                              w_tbl_we;
    logic                              w_last_ctx;
    logic                              w_last_pass;
    logic [NUM_OUTPUTS-1:0][SEL_W-1:0] w_rd_data;
    logic [NUM_OUTPUTS-1:0][SEL_W-1:0] w_ident;

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_ident
        assign w_ident[k] = SEL_W'(k % NUM_INPUTS);
    end

    assign w_num_ok    = (num_ctx != '0) && (32'(num_ctx) <= NUM_CTX);
    assign w_addr_ok   = 32'(cfg_addr) < NUM_CTX;
    // Writes are only safe while the table is not being replayed.
    assign w_tbl_we    = cfg_we && w_addr_ok && (r_state != S_RUN);
    assign w_last_ctx  = ({1'b0, r_ctx} == (r_num - NUMC_W'(1)));
    assign w_last_pass = (r_pass == r_rep);
    assign busy_o      = (r_state == S_RUN);

    xbar_ctx_table #(
        .NUM_INPUTS  (NUM_INPUTS),
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .NUM_CTX     (NUM_CTX)
    ) u_ctx_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_tbl_we),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_raddr (r_ctx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_num     <= '0;
            r_rep     <= '0;
            r_pass    <= '0;
            r_ctx     <= '0;
            select_o  <= w_ident;
            ctx_idx_o <= '0;
            cb_en_o   <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            cb_en_o <= 1'b0;
            done_o  <= 1'b0;
            // Rejected requests: bad start length from IDLE, any write in RUN, any
            // out-of-range write address. Starts outside IDLE are silently ignored.
            err_o   <= (cfg_we && (!w_addr_ok || (r_state == S_RUN))) ||
                       (start && (r_state == S_IDLE) && !w_num_ok);
            case (r_state)
                S_IDLE: begin
                    if (start && w_num_ok) begin
                        r_state <= S_RUN;
                        r_num   <= num_ctx;
                        r_rep   <= repeat_cnt;
                        r_ctx   <= '0;
                        r_pass  <= '0;
                    end
                end
                S_RUN: begin
                    // Stop wins over completion: no final context, no done pulse.
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else begin
                        select_o  <= w_rd_data;
                        ctx_idx_o <= r_ctx;
                        cb_en_o   <= 1'b1;
                        if (w_last_ctx) begin
                            r_ctx <= '0;
                            if (w_last_pass) begin
                                r_state <= S_DONE;
                            end else begin
                                r_pass <= r_pass + 8'd1;
                            end
                        end else begin
                            r_ctx <= r_ctx + CTX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_cfg_sequencer.sv
module tb_xbar_cfg_sequencer;
    import xbar_cfg_sequencer_pkg::*;

    localparam int NI = 14;
    localparam int NO = 16;
    localparam int NC = 8;
    localparam int SW = $clog2(NI);

    typedef struct {
        bit         is_done;
        logic [2:0] ctx;
        sel_vec_t   sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    sel_vec_t   cfg_data;
    logic       start;
    logic [3:0] num_ctx;
    logic [7:0] repeat_cnt;
    logic       stop;
    sel_vec_t   select_o;
    logic       cb_en_o;
    logic [2:0] ctx_idx_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    always #5 clk = ~clk;

    xbar_cfg_sequencer #(
        .NUM_INPUTS  (NI),
        .NUM_OUTPUTS (NO),
        .NUM_CTX     (NC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .num_ctx    (num_ctx),
        .repeat_cnt (repeat_cnt),
        .stop       (stop),
        .select_o   (select_o),
        .cb_en_o    (cb_en_o),
        .ctx_idx_o  (ctx_idx_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    int       checks = 0;
    int       errors = 0;
    exp_t     expq[$];
    int       lenq[$];
    int       exp_err = 0;
    int       run_len = 0;
    sel_vec_t mdl_tbl [NC];
    sel_vec_t hold_sel;
    logic [2:0] hold_ctx;

    function automatic sel_vec_t identity();
        sel_vec_t v;
        for (int k = 0; k < NO; k++) v[k] = SW'(k % NI);
        return v;
    endfunction

    function automatic sel_vec_t rand_sel();
        sel_vec_t v;
        for (int k = 0; k < NO; k++) v[k] = SW'($urandom_range(NI - 1, 0));
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: consumes expected crossbar contexts, done pulses and error pulses.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (cb_en_o) begin
                run_len++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL cb_unexpected ctx=%0d sel=%h", ctx_idx_o, select_o);
                end else begin
                    e = expq.pop_front();
                    if (e.is_done || ctx_idx_o !== e.ctx || select_o !== e.sel) begin
                        errors++;
                        $display("FAIL cb_ctx actual ctx=%0d sel=%h expected done=%0d ctx=%0d sel=%h",
                                 ctx_idx_o, select_o, e.is_done, e.ctx, e.sel);
                    end
                end
            end else if (run_len > 0) begin
                checks++;
                if (lenq.size() == 0) begin
                    errors++;
                    $display("FAIL cb_run_len actual=%0d expected=none", run_len);
                end else if (lenq[0] != run_len) begin
                    errors++;
                    $display("FAIL cb_run_len actual=%0d expected=%0d", run_len, lenq[0]);
                    void'(lenq.pop_front());
                end else begin
                    void'(lenq.pop_front());
                end
                run_len = 0;
            end
            if (done_o) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected actual=1 expected=0");
                end else begin
                    e = expq.pop_front();
                    if (!e.is_done || cb_en_o) begin
                        errors++;
                        $display("FAIL done_order actual done=1 cb=%0d expected ctx=%0d", cb_en_o, e.ctx);
                    end
                end
            end
            if (err_o) begin
                checks++;
                if (exp_err == 0) begin
                    errors++;
                    $display("FAIL err_unexpected actual=1 expected=0");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    task automatic cfg_write(input logic [2:0] a, input sel_vec_t d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        mdl_tbl[a] = d;
    endtask

    task automatic bad_start(input int n);
        @(negedge clk);
        start = 1'b1; num_ctx = 4'(n); repeat_cnt = 8'($urandom);
        exp_err++;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bad_start_err", 64'(exp_err), 64'd0);
        check("bad_start_busy", 64'(busy_o), 64'd0);
    endtask

    task automatic drained(input string name);
        check({name, "_expq"}, 64'(expq.size()), 64'd0);
        check({name, "_lenq"}, 64'(lenq.size()), 64'd0);
        check({name, "_err"}, 64'(exp_err), 64'd0);
    endtask

    // s: stop at run cycle s (0 = none); wc: write at run cycle wc (0 = none), wa<0 random addr;
    // jc: junk start at run cycle jc; wws: write together with start.
    task automatic run_seq(input int n, input int rep, input int s, input int wc,
                           input int wa, input int jc, input bit wws);
        int total, delivered, last_c;
        logic [2:0] a;
        sel_vec_t d;
        exp_t e;
        total = n * (rep + 1);
        @(negedge clk);
        start = 1'b1; num_ctx = 4'(n); repeat_cnt = 8'(rep);
        if (wws) begin
            a = 3'($urandom_range(NC - 1, 0)); d = rand_sel();
            cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
            mdl_tbl[a] = d;
        end
        delivered = (s == 0) ? total : s - 1;
        for (int i = 0; i < delivered; i++) begin
            e.is_done = 1'b0; e.ctx = 3'(i % n); e.sel = mdl_tbl[i % n];
            expq.push_back(e);
        end
        if (s == 0) begin
            e.is_done = 1'b1; e.ctx = '0; e.sel = '0;
            expq.push_back(e);
        end
        if (delivered > 0) begin
            lenq.push_back(delivered);
            hold_sel = mdl_tbl[(delivered - 1) % n];
            hold_ctx = 3'((delivered - 1) % n);
        end
        last_c = (s == 0) ? total + 1 : s;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            start = 1'b0; cfg_we = 1'b0; stop = 1'b0;
            if (c == 1) check("busy_in_run", 64'(busy_o), 64'd1);
            if (c == s) stop = 1'b1;
            if (c == wc) begin
                a = (wa < 0) ? 3'($urandom_range(NC - 1, 0)) : 3'(wa);
                d = rand_sel();
                cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
                if (c <= total) exp_err++;
                else mdl_tbl[a] = d;
            end
            if (c == jc) begin
                start = 1'b1; num_ctx = 4'($urandom_range(15, 0)); repeat_cnt = 8'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0; stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drained("seq");
        check("idle_busy", 64'(busy_o), 64'd0);
        check("idle_cb_en", 64'(cb_en_o), 64'd0);
        check("hold_select", select_o, hold_sel);
        check("hold_ctx_idx", 64'(ctx_idx_o), 64'(hold_ctx));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cb_en"}, 64'(cb_en_o), 64'd0);
        check({name, "_busy"}, 64'(busy_o), 64'd0);
        check({name, "_done"}, 64'(done_o), 64'd0);
        check({name, "_err"}, 64'(err_o), 64'd0);
        check({name, "_ctx_idx"}, 64'(ctx_idx_o), 64'd0);
        check({name, "_select"}, select_o, identity());
    endtask

    task automatic reset_mid_run();
        exp_t e;
        @(negedge clk);
        start = 1'b1; num_ctx = 4'd4; repeat_cnt = 8'd2;
        for (int i = 0; i < 2; i++) begin
            e.is_done = 1'b0; e.ctx = 3'(i); e.sel = mdl_tbl[i];
            expq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        for (int i = 0; i < NC; i++) mdl_tbl[i] = identity();
        hold_sel = identity(); hold_ctx = '0;
        check("mid_reset_expq", 64'(expq.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        drained("after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int n, rep, total, s, last_c, wc, jc;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; num_ctx = '0; repeat_cnt = '0; stop = 1'b0;
        for (int i = 0; i < NC; i++) mdl_tbl[i] = identity();
        hold_sel = identity(); hold_ctx = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Three distinct contexts, two passes.
        for (int i = 0; i < 3; i++) cfg_write(3'(i), rand_sel());
        run_seq(3, 1, 0, 0, -1, 0, 1'b0);
        // Out-of-range lengths.
        bad_start(0);
        bad_start(9);
        // Stop in the third run cycle.
        run_seq(4, 0, 3, 0, -1, 0, 1'b0);
        // Write during run is rejected; following run still sees the old entry 1.
        run_seq(3, 0, 0, 1, 1, 2, 1'b0);
        run_seq(3, 0, 0, 0, -1, 0, 1'b0);
        // Write alongside start is seen by the sequence.
        run_seq(3, 0, 0, 0, -1, 0, 1'b1);
        // Reset mid-run, then replay the identity table.
        reset_mid_run();
        run_seq(8, 0, 0, 0, -1, 0, 1'b0);
        // Single context, maximum passes.
        run_seq(1, 255, 0, 0, -1, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(99, 0) < 15) begin
                bad_start(($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(15, 9)));
            end
            repeat ($urandom_range(2, 0)) cfg_write(3'($urandom_range(NC - 1, 0)), rand_sel());
            n = $urandom_range(NC, 1);
            rep = $urandom_range(3, 0);
            total = n * (rep + 1);
            s = ($urandom_range(99, 0) < 25) ? int'($urandom_range(total, 1)) : 0;
            last_c = (s == 0) ? total + 1 : s;
            wc = ($urandom_range(99, 0) < 30) ? int'($urandom_range(last_c, 1)) : 0;
            jc = ($urandom_range(99, 0) < 30) ? int'($urandom_range(last_c, 1)) : 0;
            run_seq(n, rep, s, wc, -1, jc, $urandom_range(99, 0) < 20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbar_cfg_sequencer.md
XBAR_CFG_SEQUENCER -- requirements
Module: xbar_cfg_sequencer
Interface
REQ-001 Parameters SHALL be: NUM_INPUTS, default 14, crossbar input count; NUM_OUTPUTS, default 16, crossbar output count; NUM_CTX, default 8, context table depth; SEL_W = $clog2(NUM_INPUTS), select width per output (derived).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cfg_we  input  1  context table write strobe.
REQ-005 cfg_addr  input  $clog2(NUM_CTX)  table entry to write.
REQ-006 cfg_data  input  NUM_OUTPUTS x SEL_W  packed per-output select vector to store.
REQ-007 start  input  1  single-cycle request to begin a sequence.
REQ-008 num_ctx  input  $clog2(NUM_CTX)+1  contexts per pass, valid range 1..NUM_CTX, sampled with start.
REQ-009 repeat_cnt  input  8  extra passes, sampled with start; total passes = repeat_cnt+1.
REQ-010 stop  input  1  abort request.
REQ-011 select_o  output  NUM_OUTPUTS x SEL_W  per-output select to the crossbar, registered.
REQ-012 cb_en_o  output  1  crossbar enable, registered, high only while a context is being driven.
REQ-013 ctx_idx_o  output  $clog2(NUM_CTX)  index of the context on select_o, registered.
REQ-014 busy_o  output  1  high in RUN.
REQ-015 done_o  output  1  one-cycle pulse on normal sequence completion.
REQ-016 err_o  output  1  one-cycle pulse on any rejected request.
Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 IDLE->RUN on start with 1<=num_ctx<=NUM_CTX; num_ctx, repeat_cnt latched; ctx and pass counters cleared.
REQ-019 start with num_ctx==0 or >NUM_CTX SHALL be ignored and pulse err_o the next cycle; FSM stays IDLE.
REQ-020 Latency: start sampled at edge T; from edge T+1 select_o=table[0], ctx_idx_o=0, cb_en_o=1.
REQ-021 In RUN, each cycle SHALL advance ctx by one; after ctx==num_ctx-1 ctx wraps to 0 and pass counter increments.
REQ-022 After the last context of pass repeat_cnt, FSM SHALL enter DONE: cb_en_o=0, done_o=1 for exactly one cycle, then IDLE.
REQ-023 cb_en_o SHALL be high for exactly num_ctx*(repeat_cnt+1) consecutive cycles per completed sequence.
REQ-024 stop in RUN SHALL move to IDLE at the next edge, cb_en_o=0, no done_o; stop takes priority over completion in the same cycle.
REQ-025 start while in RUN or DONE SHALL be ignored without err_o.
REQ-026 cfg_we in IDLE or DONE SHALL write table[cfg_addr] at the edge; cfg_we in RUN SHALL be dropped and pulse err_o.
REQ-027 cfg_addr >= NUM_CTX SHALL be dropped and pulse err_o.
REQ-028 Outside RUN, select_o and ctx_idx_o SHALL hold their last driven values.
REQ-029 Simultaneous start and cfg_we in IDLE: write completes and the sequence uses the new value if the addresses match (write-first).
Reset
REQ-030 On rst_n low, asynchronously: FSM=IDLE; cb_en_o, busy_o, done_o, err_o=0; ctx_idx_o=0; counters=0.
REQ-031 Reset SHALL set select_o and every table entry to identity: output k selects k mod NUM_INPUTS.
REQ-032 Reset asserted mid-RUN SHALL abort immediately, with no done_o after release.
Structure
REQ-033 A shared package SHALL hold the FSM state enum, NUM_INPUTS/NUM_OUTPUTS/NUM_CTX defaults and the select vector typedef, shared with the crossbar.
REQ-034 The context table SHALL be a sub-module xbar_ctx_table: flop array, one write port, one combinational read port, identity reset.
Verification
REQ-035 Write table[0..2] with distinct patterns, start num_ctx=3, repeat_cnt=1 -> select_o sequence 0,1,2,0,1,2 over 6 cycles with cb_en_o=1, then done_o pulse, then IDLE.
REQ-036 start num_ctx=0, and separately num_ctx=9 -> err_o pulses once each; cb_en_o stays 0.
REQ-037 stop during the 3rd RUN cycle of num_ctx=4, repeat_cnt=0 -> cb_en_o=0 next cycle, done_o never asserted.
REQ-038 cfg_we during RUN to entry 1 -> err_o pulse; the next sequence still outputs the old table[1].
REQ-039 Assert rst_n low mid-RUN -> all outputs at reset values immediately; select_o is identity.
REQ-040 num_ctx=1, repeat_cnt=255 -> cb_en_o high exactly 256 cycles, ctx_idx_o constant 0.
